sbox_seq_ctrl: RTL and testbench
================================

Name: sbox_seq_ctrl

Overview:
- Time-multiplexed S-layer controller for the DES F-function.
- Accepts a 48-bit post-expansion/key-XOR word and evaluates the eight DES S-boxes one (or two) per cycle through a single shared lookup path.
- Assembles the 32-bit S-layer result and returns it over a valid/ready handshake.
- Sits between the E/key-mix stage and the P-permutation in the area-reduced round datapath.

Parameters:
- PIPE_IN, 0, when 1 the selected 6-bit chunk and its box index are registered before lookup; adds one cycle of latency and shortens the critical path.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept in_data this cycle
- in_data  input  48  S-layer input; bits [47:42] feed S1 … bits [5:0] feed S8
- out_valid  output  1  out_data holds a completed result
- out_ready  input  1  consumer accepts out_data
- out_data  output  32  S-layer output; S1 result in [31:28] … S8 result in [3:0]
- flush  input  1  synchronous abort; returns to IDLE and discards work
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, asynchronous) puts the block in IDLE with in_ready=1, out_valid=0, out_data=0, busy=0, index=0, and clears the capture and pipe registers.
- States: IDLE, RUN, DRAIN (present only when PIPE_IN=1), DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture in_data, clear out_data, set idx=0, go to RUN.
- RUN: each cycle, the chunk at idx is sliced as captured[47-6*idx -: 6]. Row = {b5,b0}, column = b4..b1, using the standard DES row/column convention. The 4-bit result is written to out_data[31-4*idx -: 4], then idx increments.
  - After idx=7 is written, go to DONE, or to DRAIN when PIPE_IN=1 (the last lookup lands in DRAIN).
- idx is 3 bits. It stops at 7 and never wraps inside a job; it is reset to 0 on every accept.
- DONE: out_valid=1 and out_data is held stable until out_valid&&out_ready.
  - in_ready = out_ready in DONE, so a new word can be accepted on the same edge the result is taken.
  - Accept with handshake: go to RUN with the new capture.
  - Handshake with no accept: go to IDLE.
- Latency, from the accept edge to the edge where out_valid rises: 8 cycles (PIPE_IN=0) or 9 cycles (PIPE_IN=1).
- in_ready=0 throughout RUN and DRAIN. in_valid during these states is ignored and does not need to be held.
- flush takes priority over every other event, including a simultaneous accept or output handshake. The next state is IDLE, out_valid=0, out_data=0, and the job is lost.
- rst_n asserted mid-job has the same effect as reset; no partial output is ever presented.
- out_data bits not yet written read 0 while in RUN. Consumers must not sample out_data unless out_valid=1.

Optional Feature:
- SBOX_PAR2_EN defined: two S-boxes are evaluated per cycle (pairs S1/S2, S3/S4, S5/S6, S7/S8).
  - idx steps by 2, and the lookup path is instantiated twice.
  - Latency is 4 cycles (5 cycles with PIPE_IN=1).
- Undefined: one S-box per cycle as described above.
- Handshake, flush and reset behaviour are identical in both builds.

Decomposition:
- Shared package des_pkg holds:
  - localparams SBOX_IN_W=6, SBOX_OUT_W=4, NUM_SBOX=8, SLAYER_IN_W=48, SLAYER_OUT_W=32
  - state enum typedef sbox_seq_state_t
  - helper function for row/column extraction
- Sub-module sbox_sel: combinational; a 3-bit box index and a 6-bit chunk in, a 4-bit result out.
  - It wraps the existing sbox1…sbox8 instances and muxes their outputs by index.
  - It is instantiated once, or twice under SBOX_PAR2_EN.

Test Plan:
- Known-answer: in_data=48'h6117BA866527 -> out_data=32'h5C82B597, out_valid rises exactly 8 cycles after the accept edge (PIPE_IN=0).
- Corner vectors: 48'h000000000000 -> 32'hEFA72C4D; 48'hFFFFFFFFFFFF -> 32'hD9CE3DCB; repeat with PIPE_IN=1 and check latency 9.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_data stable, in_ready=0. Then assert out_ready together with in_valid and a new word -> accepted on the same edge, the second result is correct, and there are no idle bubbles.
- Flush: assert flush at idx=4 with in_valid=1 on the same cycle -> next cycle IDLE, out_valid=0, busy=0, the concurrent input is not accepted, and the following job returns its correct result.
- Reset mid-job: drop rst_n asynchronously at idx=3 -> outputs reach their reset values without waiting for a clock edge; after release, the known-answer vector passes.
- SBOX_PAR2_EN build: run all of the above vectors -> identical results, latency 4 (5 with PIPE_IN=1).

Source files
------------

// File: rtl/des_pkg.sv
// des_pkg: shared DES S-layer widths, sequencer state type and S-box tables.
package des_pkg;

    localparam int unsigned SBOX_IN_W    = 6;
    localparam int unsigned SBOX_OUT_W   = 4;
    localparam int unsigned NUM_SBOX     = 8;
    localparam int unsigned SLAYER_IN_W  = 48;
    localparam int unsigned SLAYER_OUT_W = 32;
    localparam int unsigned SBOX_TBL_W   = 64 * SBOX_OUT_W;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } sbox_seq_state_t;

    // Entry (row*16 + col) sits at nibble [255-4*entry -: 4]; rows are 16-nibble groups.
    localparam logic [SBOX_TBL_W-1:0] SBOX_TBL [NUM_SBOX] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // Row = {b5,b0}, column = b4..b1, folded into a flat table address.
    function automatic logic [SBOX_IN_W-1:0] sbox_addr(input logic [SBOX_IN_W-1:0] chunk);
        return {chunk[5], chunk[0], chunk[4:1]};
    endfunction

endpackage

// File: rtl/sbox_seq_ctrl_if.sv
// sbox_seq_ctrl_if: valid/ready input and output channels of the S-layer sequencer.
interface sbox_seq_ctrl_if;
    import des_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [SLAYER_IN_W-1:0]  in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [SLAYER_OUT_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );

endinterface

// File: rtl/sbox_sel.sv
// sbox_sel: combinational lookup of one 6-bit chunk through S-box number idx (0 = S1).
module sbox_sel
    import des_pkg::*;
(
    input  logic [2:0]            idx,
    input  logic [SBOX_IN_W-1:0]  chunk,
    output logic [SBOX_OUT_W-1:0] res
);

    logic [SBOX_IN_W-1:0]  addr;
    logic [SBOX_OUT_W-1:0] box_res [NUM_SBOX];

    assign addr = sbox_addr(chunk);

    for (genvar b = 0; b < NUM_SBOX; b++) begin : g_box
        assign box_res[b] = SBOX_TBL[b][SBOX_OUT_W * (63 - addr) +: SBOX_OUT_W];
    end

    assign res = box_res[idx];

endmodule

// File: rtl/sbox_seq_ctrl.sv
// sbox_seq_ctrl: time-multiplexed DES S-layer; one S-box per cycle, or two per cycle when
// SBOX_PAR2_EN is defined. PIPE_IN registers the lookup operands (adds a DRAIN cycle).
module sbox_seq_ctrl
    import des_pkg::*;
#(
    parameter int unsigned PIPE_IN = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    output logic           busy,
    sbox_seq_ctrl_if.slave bus
);

`ifdef SBOX_PAR2_EN
    localparam int unsigned Lanes = 2;
`else
    localparam int unsigned Lanes = 1;
`endif
    localparam logic [2:0] LastIdx = 3'(NUM_SBOX - Lanes);

    sbox_seq_state_t         state_q;
    logic [SLAYER_IN_W-1:0]  cap_q;
    logic [2:0]              idx_q;
    logic [SLAYER_OUT_W-1:0] out_data_q;
    logic                    out_valid_q;

    logic [2:0]            sel_idx   [Lanes];
    logic [SBOX_IN_W-1:0]  sel_chunk [Lanes];
    logic [2:0]            lk_idx    [Lanes];
    logic [SBOX_IN_W-1:0]  lk_chunk  [Lanes];
    logic [SBOX_OUT_W-1:0] lk_res    [Lanes];
    logic                  lk_we;
    logic                  accept;

    always_comb begin
        for (int unsigned l = 0; l < Lanes; l++) begin
            sel_idx[l]   = idx_q + 3'(l);
            sel_chunk[l] = cap_q[SLAYER_IN_W - 1 - SBOX_IN_W * sel_idx[l] -: SBOX_IN_W];
        end
    end

    if (PIPE_IN != 0) begin : g_pipe
        logic [2:0]           pipe_idx_q   [Lanes];
        logic [SBOX_IN_W-1:0] pipe_chunk_q [Lanes];
        logic                 pipe_vld_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pipe_vld_q <= 1'b0;
                for (int unsigned l = 0; l < Lanes; l++) begin
                    pipe_idx_q[l]   <= '0;
                    pipe_chunk_q[l] <= '0;
                end
            end else begin
                pipe_vld_q <= (state_q == StRun) && !flush;
                for (int unsigned l = 0; l < Lanes; l++) begin
                    pipe_idx_q[l]   <= sel_idx[l];
                    pipe_chunk_q[l] <= sel_chunk[l];
                end
            end
        end

        always_comb begin
            lk_we = pipe_vld_q;
            for (int unsigned l = 0; l < Lanes; l++) begin
                lk_idx[l]   = pipe_idx_q[l];
                lk_chunk[l] = pipe_chunk_q[l];
            end
        end
    end else begin : g_nopipe
        always_comb begin
            lk_we = (state_q == StRun);
            for (int unsigned l = 0; l < Lanes; l++) begin
                lk_idx[l]   = sel_idx[l];
                lk_chunk[l] = sel_chunk[l];
            end
        end
    end

    for (genvar l = 0; l < Lanes; l++) begin : g_lane
        sbox_sel u_sbox_sel (
            .idx   (lk_idx[l]),
            .chunk (lk_chunk[l]),
            .res   (lk_res[l])
        );
    end

    // A result taken in DONE frees the block on the same edge, so ready follows out_ready.
    assign bus.in_ready  = !flush &&
                           ((state_q == StIdle) || ((state_q == StDone) && bus.out_ready));
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state_q != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cap_q       <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= StIdle;
            cap_q       <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (lk_we) begin
                for (int unsigned l = 0; l < Lanes; l++) begin
                    out_data_q[SLAYER_OUT_W - 1 - SBOX_OUT_W * lk_idx[l] -: SBOX_OUT_W] <= lk_res[l];
                end
            end
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q    <= StRun;
                        cap_q      <= bus.in_data;
                        idx_q      <= '0;
                        out_data_q <= '0;
                    end
                end
                StRun: begin
                    if (idx_q == LastIdx) begin
                        state_q     <= (PIPE_IN != 0) ? StDrain : StDone;
                        out_valid_q <= (PIPE_IN == 0);
                    end else begin
                        idx_q <= idx_q + 3'(Lanes);
                    end
                end
                StDrain: begin
                    state_q     <= StDone;
                    out_valid_q <= 1'b1;
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (accept) begin
                            state_q    <= StRun;
                            cap_q      <= bus.in_data;
                            idx_q      <= '0;
                            out_data_q <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_seq_ctrl.sv
// tb_sbox_seq_ctrl: scoreboard bench driving a PIPE_IN=0 and a PIPE_IN=1 instance in turn.
module tb_sbox_seq_ctrl;
    import des_pkg::*;

`ifdef SBOX_PAR2_EN
    localparam int unsigned BaseLat = 4;
`else
    localparam int unsigned BaseLat = 8;
`endif

    localparam logic [47:0] VecKat  = 48'h6117BA866527;
    localparam logic [31:0] ExpKat  = 32'h5C82B597;
    localparam logic [47:0] VecZero = 48'h000000000000;
    localparam logic [31:0] ExpZero = 32'hEFA72C4D;
    localparam logic [47:0] VecOnes = 48'hFFFFFFFFFFFF;
    localparam logic [31:0] ExpOnes = 32'hD9CE3DCB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [47:0] in_data;
    logic [31:0] in_exp;
    logic        out_ready;
    logic        flush;
    logic        sel;
    logic        busy0, busy1;

    logic        o_in_ready, o_out_valid, o_busy;
    logic [31:0] o_out_data;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    sbox_seq_ctrl_if bus0 ();
    sbox_seq_ctrl_if bus1 ();

    assign bus0.in_valid  = !sel && in_valid;
    assign bus0.in_data   = in_data;
    assign bus0.out_ready = sel || out_ready;
    assign bus1.in_valid  = sel && in_valid;
    assign bus1.in_data   = in_data;
    assign bus1.out_ready = !sel || out_ready;

    sbox_seq_ctrl #(.PIPE_IN(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush && !sel),
        .busy  (busy0),
        .bus   (bus0)
    );

    sbox_seq_ctrl #(.PIPE_IN(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush && sel),
        .busy  (busy1),
        .bus   (bus1)
    );

    assign o_in_ready  = sel ? bus1.in_ready  : bus0.in_ready;
    assign o_out_valid = sel ? bus1.out_valid : bus0.out_valid;
    assign o_out_data  = sel ? bus1.out_data  : bus0.out_data;
    assign o_busy      = sel ? busy1          : busy0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (pipe_in=%0d): got %0h expected %0h", tag, sel, got, exp);
        end
    endtask

    // Scoreboard: expectations pushed on accept, popped when out_valid rises.
    logic [31:0] exp_q [$];
    int unsigned acc_q [$];
    int unsigned cyc = 0;
    logic        prev_valid = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n || flush) begin
                exp_q.delete();
                acc_q.delete();
                prev_valid = 1'b0;
            end else begin
                if (o_out_valid && !prev_valid) begin
                    chk_eq("pending_jobs", exp_q.size(), 1);
                    if (exp_q.size() > 0) begin
                        chk_eq("out_data", o_out_data, exp_q.pop_front());
                        chk_eq("latency", cyc - acc_q.pop_front() - 1, BaseLat + sel);
                    end
                end
                if (in_valid && o_in_ready) begin
                    exp_q.push_back(in_exp);
                    acc_q.push_back(cyc);
                end
                prev_valid = o_out_valid;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_eq("rst_in_ready", o_in_ready, 1);
        chk_eq("rst_out_valid", o_out_valid, 0);
        chk_eq("rst_out_data", o_out_data, 0);
        chk_eq("rst_busy", o_busy, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic send(input logic [47:0] d, input logic [31:0] e);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_exp   = e;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = o_in_ready;
        end
        chk_eq("accept_seen", ok, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            ok = o_out_valid;
        end
        chk_eq("result_seen", ok, 1);
        tick();
    endtask

    task automatic run_suite();
        int unsigned bad;
        send(VecKat, ExpKat);   wait_valid();
        send(VecZero, ExpZero); wait_valid();
        send(VecOnes, ExpOnes); wait_valid();

        // Backpressure, then a new word accepted on the edge the held result is taken.
        out_ready = 1'b0;
        send(VecZero, ExpZero);
        wait_valid();
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_out_data !== ExpZero || o_in_ready !== 1'b0 || o_out_valid !== 1'b1) bad++;
        end
        chk_eq("bp_hold_errs", bad, 0);
        tick();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = VecOnes;
        in_exp    = ExpOnes;
        @(negedge clk);
        chk_eq("bp_same_edge_ready", o_in_ready, 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk_eq("bp_no_bubble_busy", o_busy, 1);
        chk_eq("bp_valid_dropped", o_out_valid, 0);
        tick();
        wait_valid();

        // Flush at idx=4 with a competing input word.
        send(VecOnes, ExpOnes);
        repeat (4) tick();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = VecZero;
        in_exp   = ExpZero;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk_eq("flush_busy", o_busy, 0);
        chk_eq("flush_out_valid", o_out_valid, 0);
        chk_eq("flush_out_data", o_out_data, 0);
        chk_eq("flush_in_ready", o_in_ready, 1);
        repeat (12) tick();
        send(VecKat, ExpKat);
        wait_valid();

        // Asynchronous reset at idx=3.
        send(VecKat, ExpKat);
        repeat (3) tick();
        do_reset();
        send(VecKat, ExpKat);
        wait_valid();
        repeat (2) tick();
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_exp    = '0;
        out_ready = 1'b1;
        flush     = 1'b0;
        sel       = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            do_reset();
            run_suite();
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

endmodule
